// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port among NREQ writeback sources.
// Latency 1 cycle (accept -> registered write); wb_stall or rst blocks every grant.
module regfile_wb_arbiter #(
    parameter int NREQ   = 3,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_stall,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     regwrite,
    output logic [ADDR_W-1:0]        REG_address_wb,
    output logic [DATA_W-1:0]        data_wb,
    output logic [2:0]               grant_id
);

    logic [2:0]        last_ptr;
    logic [2:0]        win;
    logic              found;
    logic              take;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    // Scan starts just past the last winner, so it gets lowest priority next time.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req_valid[(int'(last_ptr) + k) % NREQ]) begin
                found = 1'b1;
                win   = 3'((int'(last_ptr) + k) % NREQ);
            end
        end
    end

    assign take      = found && !wb_stall && !rst;
    assign req_ready = take ? (NREQ'(1) << win) : '0;
    assign win_addr  = req_addr[win*ADDR_W +: ADDR_W];
    assign win_data  = req_data[win*DATA_W +: DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_ptr       <= 3'(NREQ - 1);
            regwrite       <= 1'b0;
            REG_address_wb <= '0;
            data_wb        <= '0;
            grant_id       <= '0;
        end else if (take) begin
            last_ptr       <= win;
            grant_id       <= win;
            REG_address_wb <= win_addr;
            data_wb        <= win_data;
            // r0 is hardwired zero: accept the handshake but suppress the write.
            regwrite       <= (win_addr != '0);
        end else begin
            regwrite       <= 1'b0;
        end
    end

endmodule
